// File: rtl/mux_seq_pkg.sv
// mux_seq_pkg: shared state encoding and select-order helpers for the mux scan sequencer
package mux_seq_pkg;
  localparam int SEL_W_DEF = 3;
  localparam int SEL_MAX_W = 8;
  typedef logic [SEL_MAX_W-1:0] sel_t;
  typedef enum logic [1:0] {IDLE, SCAN, CHECK} state_t;
  function automatic sel_t first_sel(input bit lsb_first, input sel_t last_idx);
    return lsb_first ? '0 : last_idx;
  endfunction
  function automatic sel_t next_sel(input sel_t s, input bit lsb_first);
    return lsb_first ? s + sel_t'(1) : s - sel_t'(1);
  endfunction
endpackage

// File: rtl/mux_scan_sequencer_sel_hold_timer.sv
// sel_hold_timer: per-select hold counter with terminal count on the last hold cycle
module sel_hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  logic [7:0] cnt_q, cnt_d;
  assign tc_o = cnt_q == 8'(HOLD_CYCLES - 1);
  assign cnt_d = clr_i ? '0 : !en_i ? cnt_q : tc_o ? '0 : cnt_q + 8'd1;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: scans a byte through an 8:1 mux select by select and loop-checks the result
module mux_scan_sequencer
  import mux_seq_pkg::*;
#(
  parameter int SEL_W       = SEL_W_DEF,
  parameter int HOLD_CYCLES = 4,
  parameter int LSB_FIRST   = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  DATA_VALID,
  output logic                  DATA_READY,
  input  logic [2**SEL_W-1:0]   DATA_BYTE,
  output logic [2**SEL_W-1:0]   DATA_IN,
  output logic [SEL_W-1:0]      S,
  output logic                  EN_0,
  input  logic                  DATA_OUT,
  output logic                  SER_BIT,
  output logic                  SER_VALID,
  output logic [2**SEL_W-1:0]   RX_BYTE,
  output logic                  DONE,
  output logic                  ERR,
  output logic                  BUSY
);
  localparam int N = 2**SEL_W;
  localparam logic [SEL_W-1:0] LAST_SEL = (LSB_FIRST != 0) ? SEL_W'(N - 1) : '0;
  state_t state_q;
  logic tc;
  logic [N-1:0] rx_d;
  sel_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk(CLK), .rst(RST), .clr_i(state_q != SCAN), .en_i(1'b1), .tc_o(tc)
  );
  // the final sample is folded in here so ERR is already valid in the DONE cycle
  always_comb begin
    rx_d = RX_BYTE;
    rx_d[S] = DATA_OUT;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      DATA_READY <= 1'b1;
      DATA_IN <= '0;
      S <= '0;
      EN_0 <= 1'b0;
      SER_BIT <= 1'b0;
      SER_VALID <= 1'b0;
      RX_BYTE <= '0;
      DONE <= 1'b0;
      ERR <= 1'b0;
      BUSY <= 1'b0;
    end else begin
      SER_VALID <= 1'b0;
      DONE <= 1'b0;
      case (state_q)
        IDLE: if (DATA_VALID) begin
          state_q <= SCAN;
          DATA_READY <= 1'b0;
          BUSY <= 1'b1;
          DATA_IN <= DATA_BYTE;
          S <= SEL_W'(first_sel(LSB_FIRST != 0, sel_t'(N - 1)));
          EN_0 <= 1'b1;
          RX_BYTE <= '0;
          ERR <= 1'b0;
        end
        SCAN: if (tc) begin
          SER_BIT <= DATA_OUT;
          SER_VALID <= 1'b1;
          RX_BYTE <= rx_d;
          if (S == LAST_SEL) begin
            state_q <= CHECK;
            BUSY <= 1'b0;
            EN_0 <= 1'b0;
            S <= '0;
            DONE <= 1'b1;
            ERR <= rx_d != DATA_IN;
          end else begin
            S <= SEL_W'(next_sel(sel_t'(S), LSB_FIRST != 0));
          end
        end
        default: begin
          state_q <= IDLE;
          DATA_READY <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: default-order DUT plus reversed HOLD=1 DUT checked against a scan-timeline model
module tb_mux_scan_sequencer;
  typedef struct packed {
    logic ready; logic [7:0] din; logic [2:0] s; logic en; logic ser; logic serv;
    logic [7:0] rx; logic done; logic err; logic busy;
  } out_t;
  localparam int HOLD [2] = '{4, 1};
  localparam int LSB  [2] = '{1, 0};
  logic clk = 0, rst = 1, stuck = 0, mon_en = 0;
  logic v [2];
  logic [7:0] b [2];
  logic ready [2], en [2], ser [2], serv [2], done [2], err [2], busy [2], dout [2];
  logic [7:0] din [2], rx [2];
  logic [2:0] s [2];
  out_t got [2];
  int tests = 0, fails = 0, cyc = 0;
  bit mact [2], mstuck [2];
  int mk [2];
  logic [7:0] mbyte [2], hrx [2], hdin [2];
  logic hser [2], herr [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mux_scan_sequencer #(.SEL_W(3), .HOLD_CYCLES(HOLD[g]), .LSB_FIRST(LSB[g])) dut (
      .CLK(clk), .RST(rst), .DATA_VALID(v[g]), .DATA_READY(ready[g]), .DATA_BYTE(b[g]),
      .DATA_IN(din[g]), .S(s[g]), .EN_0(en[g]), .DATA_OUT(dout[g]), .SER_BIT(ser[g]),
      .SER_VALID(serv[g]), .RX_BYTE(rx[g]), .DONE(done[g]), .ERR(err[g]), .BUSY(busy[g])
    );
  end

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      dout[d] = (d == 0 && stuck) ? 1'b0 : en[d] ? din[d][s[d]] : 1'b0;
      got[d] = {ready[d], din[d], s[d], en[d], ser[d], serv[d], rx[d], done[d], err[d], busy[d]};
    end
  end

  function automatic int selof(int d, int j);
    return LSB[d] != 0 ? j : 7 - j;
  endfunction

  function automatic logic sbit(int d, int j);
    logic [7:0] t;
    t = mbyte[d];
    return mstuck[d] ? 1'b0 : t[selof(d, j)];
  endfunction

  function automatic logic [7:0] rx_after(int d, int ns);
    logic [7:0] r;
    r = '0;
    for (int j = 0; j < ns; j++) r[selof(d, j)] = sbit(d, j);
    return r;
  endfunction

  // expected outputs as a function of cycles elapsed since the accepting edge
  function automatic out_t expect_out(int d);
    out_t e;
    int h, k, ns;
    h = HOLD[d];
    k = mk[d];
    e = '0;
    e.ready = !mact[d];
    e.din = mact[d] ? mbyte[d] : hdin[d];
    e.rx = hrx[d];
    e.ser = hser[d];
    e.err = herr[d];
    if (mact[d]) begin
      ns = (k - 1) / h;
      e.rx = rx_after(d, ns);
      e.ser = ns > 0 ? sbit(d, ns - 1) : hser[d];
      e.serv = k > 1 && (k - 1) % h == 0;
      e.err = k == 8 * h + 1 && e.rx != mbyte[d];
      if (k <= 8 * h) begin
        e.s = 3'(selof(d, (k - 1) / h));
        e.en = 1'b1;
        e.busy = 1'b1;
      end else e.done = 1'b1;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mact[d] = 0; mk[d] = 0; hrx[d] = 0; hser[d] = 0; herr[d] = 0; hdin[d] = 0;
      end else if (mact[d]) begin
        mk[d]++;
        if (mk[d] == 8 * HOLD[d] + 2) begin
          mact[d] = 0;
          hrx[d] = rx_after(d, 8);
          hser[d] = sbit(d, 7);
          herr[d] = rx_after(d, 8) != mbyte[d];
          hdin[d] = mbyte[d];
        end
      end else if (v[d]) begin
        mact[d] = 1; mk[d] = 1; mbyte[d] = b[d]; mstuck[d] = d == 0 && stuck;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        out_t e;
        e = expect_out(d);
        tests++;
        if (got[d] !== e) begin
          fails++;
          $display("FAIL model_d%0d cycle %0d got %h exp %h", d, cyc, got[d], e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] g, input logic [31:0] e);
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s got %0h exp %0h", name, g, e);
    end
  endtask

  task automatic xfer(input int d, input logic [7:0] bv, input bit keep, output int t0,
                      output int tdone, output logic [7:0] seq, output logic [23:0] sseq);
    int n;
    n = 0; seq = '0; sseq = '0;
    @(negedge clk);
    v[d] = 1; b[d] = bv;
    while (!got[d].ready && n < 100) begin @(negedge clk); n++; end
    t0 = cyc;
    @(negedge clk);
    if (!keep) v[d] = 0;
    n = 0;
    while (!got[d].done && n < 100) begin
      if (got[d].serv) seq = {seq[6:0], got[d].ser};
      if (got[d].busy) sseq = {sseq[20:0], got[d].s};
      @(negedge clk);
      n++;
    end
    if (got[d].serv) seq = {seq[6:0], got[d].ser};
    tdone = got[d].done ? cyc : -1;
  endtask

  initial begin
    int t0, td, t1, cnt;
    logic [7:0] seq;
    logic [23:0] sseq;
    v = '{0, 0}; b = '{8'h00, 8'h00};
    @(negedge clk);
    mon_en = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset_ready", got[0].ready, 1);
    chk("reset_outs", {got[0].s, got[0].en, got[0].rx, got[0].din, got[0].busy}, 0);
    cnt = 0;
    repeat (20) begin @(negedge clk); cnt += got[0].serv; end
    chk("idle_no_serv", cnt, 0);

    xfer(0, 8'h01, 0, t0, td, seq, sseq);
    chk("b01_done_lat", td - t0, 33);
    chk("b01_ser_seq", seq, 8'h80);
    chk("b01_rx", got[0].rx, 8'h01);
    chk("b01_err", got[0].err, 0);
    xfer(0, 8'h02, 0, t0, td, seq, sseq);
    chk("b02_rx", got[0].rx, 8'h02);
    xfer(0, 8'h03, 0, t0, td, seq, sseq);
    chk("b03_rx", got[0].rx, 8'h03);
    chk("b03_done_lat", td - t0, 33);

    xfer(0, 8'hA5, 1, t0, td, seq, sseq);
    chk("a5_rx", got[0].rx, 8'hA5);
    xfer(0, 8'h5A, 0, t1, td, seq, sseq);
    chk("back2back_spacing", t1 - t0, 34);
    chk("5a_rx", got[0].rx, 8'h5A);

    xfer(1, 8'hC3, 0, t0, td, seq, sseq);
    chk("c3_done_lat", td - t0, 9);
    chk("c3_ser_seq", seq, 8'hC3);
    chk("c3_sel_seq", sseq, 24'hFAC688);
    chk("c3_rx", got[1].rx, 8'hC3);

    @(negedge clk);
    stuck = 1;
    xfer(0, 8'hFF, 0, t0, td, seq, sseq);
    chk("stuck_rx", got[0].rx, 8'h00);
    chk("stuck_err", got[0].err, 1);
    @(negedge clk);
    chk("stuck_err_hold", got[0].err, 1);
    stuck = 0;
    v[0] = 1; b[0] = 8'h3C;
    @(negedge clk);
    v[0] = 0;
    chk("err_clear_on_accept", got[0].err, 0);
    repeat (40) @(negedge clk);

    v[0] = 1; b[0] = 8'h81;
    @(negedge clk);
    v[0] = 0;
    repeat (9) @(negedge clk);
    chk("mid_scan_busy", got[0].busy, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_outs", {got[0].en, got[0].s, got[0].busy, got[0].done}, 0);
    chk("abort_ready", got[0].ready, 1);
    cnt = 0;
    repeat (40) begin @(negedge clk); cnt += got[0].done; end
    chk("abort_no_done", cnt, 0);
    xfer(0, 8'h81, 0, t0, td, seq, sseq);
    chk("retry_rx", got[0].rx, 8'h81);
    chk("retry_err", got[0].err, 0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog cycle %0d got timeout exp finish", cyc);
    $fatal(1);
  end
endmodule
